// File: rtl/id_hazard_scoreboard.sv
// Register-write scoreboard and ID-stage stall controller.
// Counts in-flight writers per architectural register and holds ID on RAW or counter saturation.
module id_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2,
  parameter int STALL_TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_wen,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic                      kill_valid,
  input  logic [REG_ADDR_WIDTH-1:0] kill_addr,
  output logic                      stall_id,
  output logic                      issue_fire,
  output logic [31:0]               pending_mask,
  output logic [7:0]                stall_cnt,
  output logic                      err_timeout,
  output logic                      err_underflow
);

  localparam int NUM_REGS = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [7:0] TIMEOUT = 8'(STALL_TIMEOUT);
  localparam int SUM_W = CNT_WIDTH + 2;

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_next;
  logic [7:0] stall_cnt_next;

  logic [CNT_WIDTH-1:0] cnt      [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0]  underflow;

  logic raw1, raw2, sat;

  // Hazards look only at registered counts; a same-cycle retire does not bypass.
  always_comb begin
    raw1 = rs1_used && (rs1_addr != '0) && (cnt[rs1_addr] != '0);
    raw2 = rs2_used && (rs2_addr != '0) && (cnt[rs2_addr] != '0);
    sat  = rd_wen && (rd_addr != '0) && (cnt[rd_addr] == CNT_MAX);
    stall_id   = id_valid && (raw1 || raw2 || sat);
    issue_fire = id_valid && !stall_id;
  end

  assign cnt_next[0]     = '0;
  assign underflow[0]    = 1'b0;
  assign pending_mask[0] = 1'b0;

  // Net per-register update: +issue -wb -kill, clamped at zero.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic             inc, dec_wb, dec_kill;
    logic [SUM_W-1:0] sum, dec;

    assign inc      = issue_fire && rd_wen && (rd_addr == REG_ADDR_WIDTH'(g));
    assign dec_wb   = wb_valid && (wb_addr == REG_ADDR_WIDTH'(g));
    assign dec_kill = kill_valid && (kill_addr == REG_ADDR_WIDTH'(g));
    assign sum      = SUM_W'(cnt[g]) + SUM_W'(inc);
    assign dec      = SUM_W'(dec_wb) + SUM_W'(dec_kill);
    assign underflow[g]    = dec > sum;
    assign cnt_next[g]     = underflow[g] ? '0 : CNT_WIDTH'(sum - dec);
    assign pending_mask[g] = cnt[g] != '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    case (state)
      RUN: begin
        if (stall_id) begin
          state_next     = HOLD;
          stall_cnt_next = 8'd1;
        end else begin
          stall_cnt_next = 8'd0;
        end
      end
      HOLD: begin
        if (stall_id) begin
          if (stall_cnt != 8'hFF) stall_cnt_next = stall_cnt + 8'd1;
        end else begin
          state_next     = RUN;
          stall_cnt_next = 8'd0;
        end
      end
      default: begin
        state_next     = RUN;
        stall_cnt_next = 8'd0;
      end
    endcase
  end

  // Watchdog and underflow flags are sticky until reset and never gate issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt     <= 8'd0;
      err_timeout   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      if (stall_cnt_next >= TIMEOUT) err_timeout <= 1'b1;
      if (|underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard with an expected-value queue.
module tb_id_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, rs1_used, rs2_used, rd_wen, wb_valid, kill_valid;
  logic [4:0] rs1_addr, rs2_addr, rd_addr, wb_addr, kill_addr;
  logic       stall_id, issue_fire, err_timeout, err_underflow;
  logic [31:0] pending_mask;
  logic [7:0]  stall_cnt;

  int compared = 0;
  int mismatched = 0;

  typedef enum {S_STALL, S_FIRE, S_PEND, S_SCNT, S_ETMO, S_EUND} sig_e;
  typedef struct {
    sig_e        sig;
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  id_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_wen(rd_wen),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .kill_valid(kill_valid), .kill_addr(kill_addr),
    .stall_id(stall_id), .issue_fire(issue_fire),
    .pending_mask(pending_mask), .stall_cnt(stall_cnt),
    .err_timeout(err_timeout), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_STALL: return {31'd0, stall_id};
      S_FIRE:  return {31'd0, issue_fire};
      S_PEND:  return pending_mask;
      S_SCNT:  return {24'd0, stall_cnt};
      S_ETMO:  return {31'd0, err_timeout};
      default: return {31'd0, err_underflow};
    endcase
  endfunction

  task automatic expect_val(sig_e s, string tag, logic [31:0] v);
    exp_t e;
    e.sig = s; e.tag = tag; e.exp = v;
    sb.push_back(e);
  endtask

  // Pops every queued expectation and compares it against the live outputs.
  task automatic checkOutput();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sig);
      compared++;
      assert (obs === e.exp) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drives one ID/WB/kill slot at the falling edge and settles 1 time unit.
  task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] rd, input logic wen,
                               input logic wbv, input logic [4:0] wba,
                               input logic kv, input logic [4:0] ka);
    @(negedge clk);
    id_valid = v; rs1_addr = r1; rs1_used = u1; rs2_addr = r2; rs2_used = u2;
    rd_addr = rd; rd_wen = wen; wb_valid = wbv; wb_addr = wba;
    kill_valid = kv; kill_addr = ka;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; rs1_used = 0; rs2_used = 0; rd_wen = 0; wb_valid = 0; kill_valid = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; wb_addr = 0; kill_addr = 0;
    #12;
    expect_val(S_STALL, "rst_stall", 0);
    expect_val(S_FIRE,  "rst_fire", 0);
    expect_val(S_PEND,  "rst_pend", 0);
    expect_val(S_SCNT,  "rst_scnt", 0);
    expect_val(S_ETMO,  "rst_etmo", 0);
    expect_val(S_EUND,  "rst_eund", 0);
    checkOutput();
    @(negedge clk); rst = 1'b0;

    // RAW on x5, released one cycle after the write-back
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    expect_val(S_STALL, "iss5_stall", 0);
    expect_val(S_FIRE,  "iss5_fire", 1);
    checkOutput();
    applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect_val(S_STALL, "raw5_stall", 1);
    expect_val(S_FIRE,  "raw5_fire", 0);
    expect_val(S_PEND,  "raw5_pend", 32'h20);
    expect_val(S_SCNT,  "raw5_scnt0", 0);
    checkOutput();
    applyStimulus(1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 0);
    expect_val(S_STALL, "raw5_wb_stall", 1);
    expect_val(S_SCNT,  "raw5_scnt1", 1);
    checkOutput();
    applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect_val(S_STALL, "raw5_rel_stall", 0);
    expect_val(S_FIRE,  "raw5_rel_fire", 1);
    expect_val(S_PEND,  "raw5_rel_pend", 0);
    expect_val(S_SCNT,  "raw5_rel_scnt", 2);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    expect_val(S_SCNT,  "run_scnt", 0);
    expect_val(S_PEND,  "pend6", 32'h40);
    checkOutput();

    // Saturate x7 at three in-flight writers
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      expect_val(S_FIRE, $sformatf("sat_iss%0d", k), 1);
      checkOutput();
    end
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_val(S_STALL, "sat_stall", 1);
    expect_val(S_PEND,  "sat_pend", 32'h80);
    checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    expect_val(S_STALL, "sat_wb_stall", 1);
    checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_val(S_FIRE,  "sat_rel_fire", 1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    expect_val(S_PEND,  "x7_drained", 0);
    expect_val(S_EUND,  "x7_no_uf", 0);
    checkOutput();

    // Issue and retire to x3 in the same cycle, then wb+kill together
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 3, 0, 0);
    expect_val(S_FIRE,  "x3_iss_wb_fire", 1);
    checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    expect_val(S_PEND,  "x3_one", 32'h08);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
    expect_val(S_PEND,  "x3_zero", 0);
    expect_val(S_EUND,  "x3_no_uf", 0);
    expect_val(S_STALL, "x0_stall", 0);
    expect_val(S_FIRE,  "x0_fire", 1);
    checkOutput();
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
    expect_val(S_PEND,  "x0_pend", 0);
    expect_val(S_EUND,  "x0_no_uf", 0);
    expect_val(S_STALL, "x0_stall2", 0);
    checkOutput();

    // Long RAW hold on x10 exercises watchdog and stall_cnt saturation
    applyStimulus(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_val(S_STALL, "tmo_stall", 1);
    checkOutput();
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
      if (k == 14) expect_val(S_ETMO, "tmo_before", 0);
      if (k == 15) begin
        expect_val(S_ETMO, "tmo_set", 1);
        expect_val(S_SCNT, "tmo_scnt15", 15);
      end
      if (k == 255) expect_val(S_SCNT, "scnt_255", 255);
      if (k == 300) expect_val(S_SCNT, "scnt_sat", 255);
      checkOutput();
    end
    applyStimulus(1, 0, 0, 10, 1, 0, 0, 1, 10, 0, 0);
    expect_val(S_STALL, "tmo_wb_stall", 1);
    checkOutput();
    applyStimulus(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
    expect_val(S_FIRE,  "tmo_rel_fire", 1);
    expect_val(S_SCNT,  "tmo_rel_scnt", 255);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_val(S_SCNT,  "tmo_run_scnt", 0);
    expect_val(S_ETMO,  "tmo_sticky", 1);
    checkOutput();

    // Retire to an idle register
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    expect_val(S_EUND,  "uf_before", 0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_val(S_EUND,  "uf_set", 1);
    expect_val(S_PEND,  "uf_pend", 0);
    checkOutput();

    // Asynchronous reset in the middle of a stall
    applyStimulus(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_val(S_STALL, "mid_stall", 1);
    expect_val(S_SCNT,  "mid_scnt", 1);
    checkOutput();
    #1 rst = 1'b1;
    #1;
    expect_val(S_STALL, "arst_stall", 0);
    expect_val(S_FIRE,  "arst_fire", 1);
    expect_val(S_PEND,  "arst_pend", 0);
    expect_val(S_SCNT,  "arst_scnt", 0);
    expect_val(S_ETMO,  "arst_etmo", 0);
    expect_val(S_EUND,  "arst_eund", 0);
    checkOutput();
    @(negedge clk); rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
